// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries the decoder's control bundle through the ID/EX, EX/MEM and
// MEM/WB registers. It selects and pipelines the destination register, detects
// RAW hazards against in-flight instructions and inserts bubbles on a stall or
// flush.
// Optional build macro CTRL_PIPE_FWD_EN: when defined, EX-stage forwarding
// selects are generated and only load-use hazards stall. When undefined, the
// forwarding selects are tied to 00 and any ID/EX or EX/MEM hit stalls.
module ctrl_pipe (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic       flush_i,
  input  logic       RegWrite_i,
  input  logic       MemtoReg_i,
  input  logic       Branch_i,
  input  logic       MemRead_i,
  input  logic       MemWrite_i,
  input  logic       RegDst_i,
  input  logic       ALUSrc_i,
  input  logic [1:0] ALUOp_i,
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  input  logic [4:0] rd_i,
  output logic       stall_o,
  output logic [1:0] ex_ALUOp_o,
  output logic       ex_ALUSrc_o,
  output logic [4:0] ex_rs_o,
  output logic [4:0] ex_rt_o,
  output logic       mem_MemRead_o,
  output logic       mem_MemWrite_o,
  output logic       mem_RegWrite_o,
  output logic [4:0] mem_wr_addr_o,
  output logic       wb_RegWrite_o,
  output logic       wb_MemtoReg_o,
  output logic [4:0] wb_wr_addr_o,
  output logic [1:0] fwdA_o,
  output logic [1:0] fwdB_o
);

  typedef struct packed {
    logic       RegWrite;
    logic       MemtoReg;
    logic       MemRead;
    logic       MemWrite;
    logic       ALUSrc;
    logic [1:0] ALUOp;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dest;
  } idex_t;

  typedef struct packed {
    logic       RegWrite;
    logic       MemtoReg;
    logic       MemRead;
    logic       MemWrite;
    logic [4:0] dest;
  } exmem_t;

  typedef struct packed {
    logic       RegWrite;
    logic       MemtoReg;
    logic [4:0] dest;
  } memwb_t;

  idex_t  idex_q,  idex_d;
  exmem_t exmem_q, exmem_d;
  memwb_t memwb_q, memwb_d;

  logic use_rs, use_rt;
  logic ex_hit;
  logic issue;

  // A stage produces a usable hazard only if it writes a non-zero register
  // that equals the source being examined; register 0 is hard-wired.
  function automatic logic hit(input logic wr, input logic [4:0] dest,
                               input logic [4:0] src);
    return wr && (dest != 5'd0) && (dest == src);
  endfunction

  // Source usage of the ID instruction and its hazard against ID/EX.
  always_comb begin
    use_rs = RegWrite_i | MemRead_i | MemWrite_i | Branch_i;
    use_rt = (!ALUSrc_i && (RegWrite_i || Branch_i)) || MemWrite_i;
    ex_hit = (use_rs && hit(idex_q.RegWrite, idex_q.dest, rs_i)) ||
             (use_rt && hit(idex_q.RegWrite, idex_q.dest, rt_i));
  end

`ifdef CTRL_PIPE_FWD_EN
  // With forwarding only a load still in EX cannot supply its result in time.
  always_comb begin
    stall_o = valid_i && !flush_i && ex_hit && idex_q.MemRead;
  end

  // Forwarding selects for the EX operands; the younger EX/MEM result wins.
  always_comb begin
    fwdA_o = 2'b00;
    fwdB_o = 2'b00;
    if (hit(exmem_q.RegWrite, exmem_q.dest, idex_q.rs))
      fwdA_o = 2'b10;
    else if (hit(memwb_q.RegWrite, memwb_q.dest, idex_q.rs))
      fwdA_o = 2'b01;
    if (hit(exmem_q.RegWrite, exmem_q.dest, idex_q.rt))
      fwdB_o = 2'b10;
    else if (hit(memwb_q.RegWrite, memwb_q.dest, idex_q.rt))
      fwdB_o = 2'b01;
  end
`else
  logic mem_hit;

  // Without forwarding wait until the producer reaches WB; the register file
  // writes in the first half-cycle so a MEM/WB producer is already visible.
  always_comb begin
    mem_hit = (use_rs && hit(exmem_q.RegWrite, exmem_q.dest, rs_i)) ||
              (use_rt && hit(exmem_q.RegWrite, exmem_q.dest, rt_i));
    stall_o = valid_i && !flush_i && (ex_hit || mem_hit);
  end

  // No forwarding network in this build.
  always_comb begin
    fwdA_o = 2'b00;
    fwdB_o = 2'b00;
  end
`endif

  // Next-state of all stage registers; a non-issued slot becomes a bubble.
  always_comb begin
    issue  = valid_i && !flush_i && !stall_o;
    idex_d = '0;
    if (issue) begin
      idex_d.RegWrite = RegWrite_i;
      idex_d.MemtoReg = MemtoReg_i;
      idex_d.MemRead  = MemRead_i;
      idex_d.MemWrite = MemWrite_i;
      idex_d.ALUSrc   = ALUSrc_i;
      idex_d.ALUOp    = ALUOp_i;
      idex_d.rs       = rs_i;
      idex_d.rt       = rt_i;
      idex_d.dest     = RegDst_i ? rd_i : rt_i;
    end
    exmem_d.RegWrite = idex_q.RegWrite;
    exmem_d.MemtoReg = idex_q.MemtoReg;
    exmem_d.MemRead  = idex_q.MemRead;
    exmem_d.MemWrite = idex_q.MemWrite;
    exmem_d.dest     = idex_q.dest;
    memwb_d.RegWrite = exmem_q.RegWrite;
    memwb_d.MemtoReg = exmem_q.MemtoReg;
    memwb_d.dest     = exmem_q.dest;
  end

  // Stage registers; EX/MEM and MEM/WB advance every cycle regardless of stall.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  // Per-stage control outputs.
  always_comb begin
    ex_ALUOp_o     = idex_q.ALUOp;
    ex_ALUSrc_o    = idex_q.ALUSrc;
    ex_rs_o        = idex_q.rs;
    ex_rt_o        = idex_q.rt;
    mem_MemRead_o  = exmem_q.MemRead;
    mem_MemWrite_o = exmem_q.MemWrite;
    mem_RegWrite_o = exmem_q.RegWrite;
    mem_wr_addr_o  = exmem_q.dest;
    wb_RegWrite_o  = memwb_q.RegWrite;
    wb_MemtoReg_o  = memwb_q.MemtoReg;
    wb_wr_addr_o   = memwb_q.dest;
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Testbench for ctrl_pipe: directed scenarios plus randomized instruction
// streams checked against a history-based reference model.
module tb_ctrl_pipe;

  logic       clk = 1'b0;
  logic       rst_i, valid_i, flush_i;
  logic       RegWrite_i, MemtoReg_i, Branch_i, MemRead_i, MemWrite_i;
  logic       RegDst_i, ALUSrc_i;
  logic [1:0] ALUOp_i;
  logic [4:0] rs_i, rt_i, rd_i;
  logic       stall_o;
  logic [1:0] ex_ALUOp_o;
  logic       ex_ALUSrc_o;
  logic [4:0] ex_rs_o, ex_rt_o;
  logic       mem_MemRead_o, mem_MemWrite_o, mem_RegWrite_o;
  logic [4:0] mem_wr_addr_o;
  logic       wb_RegWrite_o, wb_MemtoReg_o;
  logic [4:0] wb_wr_addr_o;
  logic [1:0] fwdA_o, fwdB_o;

  always #5 clk = ~clk;

  ctrl_pipe dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .flush_i(flush_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .Branch_i(Branch_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .RegDst_i(RegDst_i),
    .ALUSrc_i(ALUSrc_i), .ALUOp_i(ALUOp_i), .rs_i(rs_i), .rt_i(rt_i),
    .rd_i(rd_i), .stall_o(stall_o), .ex_ALUOp_o(ex_ALUOp_o),
    .ex_ALUSrc_o(ex_ALUSrc_o), .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o),
    .mem_MemRead_o(mem_MemRead_o), .mem_MemWrite_o(mem_MemWrite_o),
    .mem_RegWrite_o(mem_RegWrite_o), .mem_wr_addr_o(mem_wr_addr_o),
    .wb_RegWrite_o(wb_RegWrite_o), .wb_MemtoReg_o(wb_MemtoReg_o),
    .wb_wr_addr_o(wb_wr_addr_o), .fwdA_o(fwdA_o), .fwdB_o(fwdB_o)
  );

  // One record per issue slot; the newest entry is in EX, then MEM, then WB.
  typedef struct {
    logic       rw, m2r, mr, mw, asrc;
    logic [1:0] aop;
    logic [4:0] rs, rt, dest;
  } rec_t;

  localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_ADDI = 4, K_J = 5;

  rec_t hist[$];
  int   total = 0;
  int   bad   = 0;
  bit   last_stall = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit hit(input rec_t s, input logic [4:0] r);
    return s.rw && (r != 5'd0) && (s.dest == r);
  endfunction

  function automatic bit model_stall();
    bit urs, urt, exh, memh, s;
    rec_t ex, mem;
    ex   = hist[$];
    mem  = hist[$-1];
    urs  = RegWrite_i || MemRead_i || MemWrite_i || Branch_i;
    urt  = (!ALUSrc_i && (RegWrite_i || Branch_i)) || MemWrite_i;
    exh  = (urs && hit(ex, rs_i)) || (urt && hit(ex, rt_i));
    memh = (urs && hit(mem, rs_i)) || (urt && hit(mem, rt_i));
`ifdef CTRL_PIPE_FWD_EN
    s = exh && ex.mr;
`else
    s = exh || memh;
`endif
    return valid_i && !flush_i && s;
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] r);
`ifdef CTRL_PIPE_FWD_EN
    if (hit(hist[$-1], r)) return 2'b10;
    if (hit(hist[$-2], r)) return 2'b01;
`endif
    return 2'b00;
  endfunction

  task automatic model_reset();
    rec_t b;
    b = '{default: '0};
    hist.delete();
    repeat (3) hist.push_back(b);
  endtask

  // Check all outputs against the model, then clock one edge.
  task automatic step();
    bit   s;
    rec_t nr, ex, mem, wb;
    #1;
    ex  = hist[$];
    mem = hist[$-1];
    wb  = hist[$-2];
    s   = model_stall();
    chk("stall", stall_o, s);
    chk("fwdA", fwdA_o, model_fwd(ex.rs));
    chk("fwdB", fwdB_o, model_fwd(ex.rt));
    chk("ex_ALUOp", ex_ALUOp_o, ex.aop);
    chk("ex_ALUSrc", ex_ALUSrc_o, ex.asrc);
    chk("ex_rs", ex_rs_o, ex.rs);
    chk("ex_rt", ex_rt_o, ex.rt);
    chk("mem_MemRead", mem_MemRead_o, mem.mr);
    chk("mem_MemWrite", mem_MemWrite_o, mem.mw);
    chk("mem_RegWrite", mem_RegWrite_o, mem.rw);
    chk("mem_wr_addr", mem_wr_addr_o, mem.dest);
    chk("wb_RegWrite", wb_RegWrite_o, wb.rw);
    chk("wb_MemtoReg", wb_MemtoReg_o, wb.m2r);
    chk("wb_wr_addr", wb_wr_addr_o, wb.dest);
    nr = '{default: '0};
    if (valid_i && !flush_i && !s)
      nr = '{RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, ALUOp_i,
             rs_i, rt_i, (RegDst_i ? rd_i : rt_i)};
    last_stall = s && !rst_i;
    @(posedge clk);
    if (rst_i) model_reset();
    else begin
      hist.push_back(nr);
      void'(hist.pop_front());
    end
    #1;
  endtask

  task automatic set_bubble();
    valid_i = 1'b0; flush_i = 1'b0;
    RegWrite_i = 0; MemtoReg_i = 0; Branch_i = 0; MemRead_i = 0;
    MemWrite_i = 0; RegDst_i = 0; ALUSrc_i = 0; ALUOp_i = 2'b00;
    rs_i = 0; rt_i = 0; rd_i = 0;
  endtask

  task automatic set_instr(input int k, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd);
    set_bubble();
    valid_i = 1'b1;
    rs_i = rs; rt_i = rt; rd_i = rd;
    case (k)
      K_R:    begin RegWrite_i = 1; RegDst_i = 1; ALUOp_i = 2'b10; end
      K_LW:   begin RegWrite_i = 1; MemRead_i = 1; MemtoReg_i = 1; ALUSrc_i = 1; end
      K_SW:   begin MemWrite_i = 1; ALUSrc_i = 1; end
      K_BEQ:  begin Branch_i = 1; ALUOp_i = 2'b01; end
      K_ADDI: begin RegWrite_i = 1; ALUSrc_i = 1; end
      default: ;
    endcase
  endtask

  task automatic drain();
    set_bubble();
    repeat (3) step();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    set_instr(K_R, 5'd1, 5'd2, 5'd5);
    @(posedge clk);
    model_reset();
    #1;

    // Reset held two cycles with a live R-type on the inputs.
    ALUOp_i = 2'b11;
    step();
    chk("rst_ex_aluop", ex_ALUOp_o, 2'b00);
    chk("rst_wb_rw", wb_RegWrite_o, 1'b0);
    step();
    chk("rst_mem_addr", mem_wr_addr_o, 5'd0);
    rst_i = 1'b0;
    step();
    chk("prop_ex_aluop", ex_ALUOp_o, 2'b11);
    set_bubble();
    step();
    chk("prop_mem_addr", mem_wr_addr_o, 5'd5);
    step();
    chk("prop_wb_rw", wb_RegWrite_o, 1'b1);
    chk("prop_wb_addr", wb_wr_addr_o, 5'd5);

    set_instr(K_LW, 5'd2, 5'd7, 5'd0);
    step();
    set_bubble();
    step();
    step();
    chk("lw_wb_m2r", wb_MemtoReg_o, 1'b1);
    chk("lw_wb_addr", wb_wr_addr_o, 5'd7);
    drain();

`ifdef CTRL_PIPE_FWD_EN
    // Load-use: one stall, then forward from MEM/WB.
    set_instr(K_LW, 5'd0, 5'd8, 5'd0);
    step();
    set_instr(K_R, 5'd8, 5'd1, 5'd10);
    #1 chk("lu_stall1", stall_o, 1'b1);
    step();
    chk("lu_bubble_rs", ex_rs_o, 5'd0);
    chk("lu_mem_rd", mem_MemRead_o, 1'b1);
    #1 chk("lu_stall2", stall_o, 1'b0);
    step();
    chk("lu_ex_rs", ex_rs_o, 5'd8);
    chk("lu_fwdA", fwdA_o, 2'b01);
    drain();

    // Forward priority: EX/MEM beats MEM/WB.
    set_instr(K_R, 5'd1, 5'd2, 5'd3);
    step();
    step();
    set_instr(K_R, 5'd3, 5'd3, 5'd6);
    step();
    chk("prio_fwdA", fwdA_o, 2'b10);
    chk("prio_fwdB", fwdB_o, 2'b10);
    drain();
`else
    // No forwarding: two stall cycles for a beq behind an add.
    set_instr(K_R, 5'd1, 5'd2, 5'd4);
    step();
    set_instr(K_BEQ, 5'd4, 5'd0, 5'd0);
    #1 chk("beq_stall1", stall_o, 1'b1);
    step();
    #1 chk("beq_stall2", stall_o, 1'b1);
    step();
    #1 chk("beq_stall3", stall_o, 1'b0);
    step();
    chk("beq_ex_rs", ex_rs_o, 5'd4);
    chk("beq_ex_aluop", ex_ALUOp_o, 2'b01);
    drain();

    // addi does not read rt.
    set_instr(K_ADDI, 5'd0, 5'd9, 5'd0);
    step();
    set_instr(K_ADDI, 5'd0, 5'd9, 5'd11);
    #1 chk("addi_nostall", stall_o, 1'b0);
    step();
    drain();
`endif

    // Flush wins over a hazard.
    set_instr(K_LW, 5'd1, 5'd4, 5'd0);
    step();
    set_instr(K_R, 5'd4, 5'd4, 5'd6);
    flush_i = 1'b1;
    #1 chk("flush_stall", stall_o, 1'b0);
    step();
    chk("flush_ex_rs", ex_rs_o, 5'd0);
    chk("flush_ex_aluop", ex_ALUOp_o, 2'b00);
    drain();

    // Writes to $0 never stall or forward but still reach WB.
    set_instr(K_R, 5'd1, 5'd2, 5'd0);
    step();
    set_instr(K_R, 5'd0, 5'd0, 5'd7);
    #1 chk("zero_stall", stall_o, 1'b0);
    step();
    chk("zero_fwdA", fwdA_o, 2'b00);
    set_bubble();
    step();
    chk("zero_wb_rw", wb_RegWrite_o, 1'b1);
    chk("zero_wb_addr", wb_wr_addr_o, 5'd0);
    drain();

    // Jump after load uses no sources.
    set_instr(K_LW, 5'd0, 5'd8, 5'd0);
    step();
    set_instr(K_J, 5'd8, 5'd8, 5'd0);
    #1 chk("jump_stall", stall_o, 1'b0);
    step();
    drain();

    // Random instruction stream; a stalled instruction is held in ID.
    last_stall = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!last_stall) begin
        if ($urandom_range(9) == 0) set_bubble();
        else set_instr(int'($urandom_range(5)), 5'($urandom_range(3)),
                       5'($urandom_range(3)), 5'($urandom_range(3)));
        if (RegWrite_i && RegDst_i) ALUOp_i = 2'($urandom_range(3));
      end
      flush_i = ($urandom_range(15) == 0);
      rst_i   = ($urandom_range(63) == 0);
      step();
    end
    rst_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Carries the control bundle produced by the ID-stage opcode decoder through the ID/EX, EX/MEM and MEM/WB pipeline registers, so each datapath stage receives its own control signals. It also selects and pipelines the destination register, detects RAW hazards against in-flight instructions, and inserts bubbles. It sits between the decoder/register-file read in ID and the EX, MEM and WB datapath muxes. Optionally, it generates forwarding selects for the EX-stage ALU operands.

## Interface
- No parameters. Register addresses are fixed at 5 bits; ALUOp is 2 bits.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `valid_i` in 1: the ID stage holds a real instruction; 0 = bubble.
- `flush_i` in 1: squash the ID-stage instruction this cycle.
- `RegWrite_i, MemtoReg_i, Branch_i, MemRead_i, MemWrite_i, RegDst_i, ALUSrc_i` in 1 each: decoder outputs for the ID instruction.
- `ALUOp_i` in 2: decoder ALUOp.
- `rs_i, rt_i, rd_i` in 5 each: register fields of the ID instruction.
- `stall_o` out 1: hold PC and IF/ID; the ID instruction is not issued this cycle.
- `ex_ALUOp_o` out 2, `ex_ALUSrc_o` out 1: EX-stage controls.
- `ex_rs_o, ex_rt_o` out 5: EX-stage source fields.
- `mem_MemRead_o, mem_MemWrite_o, mem_RegWrite_o` out 1: MEM-stage controls.
- `mem_wr_addr_o` out 5: MEM-stage destination register.
- `wb_RegWrite_o, wb_MemtoReg_o` out 1, `wb_wr_addr_o` out 5: WB-stage controls and destination.
- `fwdA_o, fwdB_o` out 2: forwarding selects for the EX ALU operands (present in all builds).

## Operation
- **Destination select:** dest = RegDst_i ? rd_i : rt_i. It is captured into ID/EX and then travels EX→MEM→WB with its stage.
- **Source usage in ID:**
  - rs is used when any of RegWrite_i, MemRead_i, MemWrite_i or Branch_i is set.
  - rt is used when (!ALUSrc_i && (RegWrite_i || Branch_i)) || MemWrite_i.
  - A jump (all-zero bundle) uses neither.
- **Hazard match:** an in-flight stage X matches when X.RegWrite=1, X.dest≠0, and X.dest equals a used source.
- **Issue:** ID/EX loads the ID bundle when valid_i && !flush_i && !stall_o. Otherwise ID/EX loads a bubble: all control bits 0, fields 0.
- **Priority:** flush_i forces stall_o=0, so a flush is never held; flush_i has priority over stall.
- **Later stages:** EX/MEM and MEM/WB advance every cycle unconditionally; a stall never freezes them.
- **Register 0:** a write to register 0 propagates to wb_RegWrite_o unchanged, but it never causes a stall or a forward.
- Branch_i is consumed only for the hazard check. It is not pipelined; branch resolution is in ID and external to this block.

## Timing
- **Reset:** on a cycle with rst_i=1, all stage registers clear at the edge. All registered outputs are then 0, and stall_o, fwdA_o and fwdB_o evaluate to 0.
  - A reset during a stall or flush discards all in-flight instructions.
- **Latency:** an issued bundle appears on ex_* 1 cycle after issue, on mem_* after 2 cycles and on wb_* after 3 cycles.
- **stall_o and fwd*_o are combinational:**
  - stall_o is computed from the current ID inputs and the registered stages.
  - fwdA_o/fwdB_o are computed from the registered stages only.
  - The datapath samples them in the same cycle.
- **Load-use:** a stall lasts exactly 1 cycle per load-use pair. On the next cycle the load is in MEM and the hazard clears.
- **Back-to-back:** a stalled instruction issues on the first cycle its hazard clears. No extra bubble is added beyond the stall cycles.

## Configuration
- **`CTRL_PIPE_FWD_EN` defined:**
  - fwdA_o is driven from ex_rs_o; 2'b10 when the EX/MEM stage matches it, else 2'b01 when the MEM/WB stage matches it, else 2'b00. EX/MEM has priority.
  - fwdB_o is driven the same way from ex_rt_o.
  - stall_o asserts only when the ID/EX stage matches and has MemRead=1 (load-use).
- **`CTRL_PIPE_FWD_EN` undefined:**
  - fwdA_o and fwdB_o are tied to 2'b00.
  - stall_o asserts when the ID/EX or EX/MEM stage matches.
  - A MEM/WB match does not stall: the register file writes in the first half-cycle and reads in the second.

## Test plan
- **Reset:** assert rst_i for 2 cycles with valid_i=1 and an R-type bundle on the inputs → every output is 0 in the cycle after the reset edge; the bundle first appears on ex_* only after rst_i drops.
- **Propagation:** issue an R-type (RegDst=1, rd=5, ALUOp=11) → ex_ALUOp_o=11 at +1, mem_wr_addr_o=5 at +2, wb_RegWrite_o=1 and wb_wr_addr_o=5 at +3; lw to rt=7 → wb_MemtoReg_o=1 and wb_wr_addr_o=7 at +3.
- **Load-use (FWD_EN):** issue lw $8, then add with rs=8 → stall_o=1 for exactly 1 cycle and ex_* shows a bubble; then the add issues; in the add's EX cycle fwdA_o=01.
- **Forward priority (FWD_EN):** issue add $3, then add $3, then sub with rs=3 and rt=3 → in the sub's EX cycle fwdA_o=10 and fwdB_o=10.
- **No-forward build:** issue add $4, then beq with rs=4 → stall_o=1 for 2 cycles and the beq issues on the 3rd; issue addi $9 writing rt=9, then addi with rt=9 and rs=0 → no stall, because rt is not a source for addi.
- **Flush, zero, jump:** flush_i=1 while a hazard is present → stall_o=0 and ID/EX receives a bubble; an add writing $0 followed by a reader of $0 → no stall and fwd=00; a jump bundle after a load → no stall.
